// File: rtl/tdc_capture_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tdc_capture_decoder: delay-line tap sampler, popcount decode, mean/min/max  |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tdc_capture_decoder #(
  parameter int N_TAPS       = 16,
  parameter int LOG2_SAMPLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_TAPS-1:0] taps,
  input  logic              start,
  input  logic              out_ready,
  output logic              busy,
  output logic              result_valid,
  output logic [7:0]        mean,
  output logic [7:0]        min_cnt,
  output logic [7:0]        max_cnt,
  output logic              sat,
  output logic              empty
);

  localparam int CNT_W = (LOG2_SAMPLES > 0) ? LOG2_SAMPLES : 1;
  localparam int ACC_W = 8 + LOG2_SAMPLES;
  localparam int POP_W = $clog2(N_TAPS + 1);
  localparam logic [CNT_W-1:0] LAST_SAMPLE = CNT_W'((1 << LOG2_SAMPLES) - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    ACCUM  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [N_TAPS-1:0] cap1_q, cap2_q;
  logic              settle_q;
  logic [CNT_W-1:0]  sample_q;
  logic [ACC_W-1:0]  acc_q;
  logic [7:0]        min_q, max_q;
  logic              sat_acc_q, empty_acc_q;

  logic [7:0]        mean_q, min_cnt_q, max_cnt_q;
  logic              sat_q, empty_q;

  logic [POP_W-1:0]  pop;
  logic [7:0]        count;
  logic [ACC_W-1:0]  acc_d;
  logic [7:0]        min_d, max_d;
  logic              sat_d, empty_d;
  logic              last_sample;

  // Popcount rather than first-zero search so bubbles in the thermometer code
  // still yield a sensible tap count.
  always_comb begin
    pop = '0;
    for (int i = 0; i < N_TAPS; i++) begin
      pop = pop + POP_W'(cap2_q[i]);
    end
  end

  assign count       = 8'(pop);
  assign acc_d       = acc_q + ACC_W'(count);
  assign min_d       = (count < min_q) ? count : min_q;
  assign max_d       = (count > max_q) ? count : max_q;
  assign sat_d       = sat_acc_q | (&cap2_q);
  assign empty_d     = empty_acc_q | ~(|cap2_q);
  assign last_sample = (sample_q == LAST_SAMPLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    busy         = 1'b0;
    result_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) state_d = SETTLE;
      end
      SETTLE: begin
        busy = 1'b1;
        if (settle_q) state_d = ACCUM;
      end
      ACCUM: begin
        busy = 1'b1;
        if (last_sample) state_d = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cap1_q      <= '0;
      cap2_q      <= '0;
      settle_q    <= 1'b0;
      sample_q    <= '0;
      acc_q       <= '0;
      min_q       <= '0;
      max_q       <= '0;
      sat_acc_q   <= 1'b0;
      empty_acc_q <= 1'b0;
      mean_q      <= '0;
      min_cnt_q   <= '0;
      max_cnt_q   <= '0;
      sat_q       <= 1'b0;
      empty_q     <= 1'b0;
    end else begin
      cap1_q <= taps;
      cap2_q <= cap1_q;
      case (state_q)
        IDLE: begin
          if (start) begin
            settle_q    <= 1'b0;
            sample_q    <= '0;
            acc_q       <= '0;
            min_q       <= 8'hFF;
            max_q       <= 8'h00;
            sat_acc_q   <= 1'b0;
            empty_acc_q <= 1'b0;
          end
        end
        SETTLE: begin
          settle_q <= ~settle_q;
        end
        ACCUM: begin
          acc_q       <= acc_d;
          min_q       <= min_d;
          max_q       <= max_d;
          sat_acc_q   <= sat_d;
          empty_acc_q <= empty_d;
          sample_q    <= last_sample ? '0 : sample_q + CNT_W'(1);
          // Result registers load from the final-sample next values so they
          // are already settled on the first DONE cycle.
          if (last_sample) begin
            mean_q    <= 8'(acc_d >> LOG2_SAMPLES);
            min_cnt_q <= min_d;
            max_cnt_q <= max_d;
            sat_q     <= sat_d;
            empty_q   <= empty_d;
          end
        end
        default: ;
      endcase
    end
  end

  assign mean    = mean_q;
  assign min_cnt = min_cnt_q;
  assign max_cnt = max_cnt_q;
  assign sat     = sat_q;
  assign empty   = empty_q;

endmodule
`default_nettype wire

// File: tb/tb_tdc_capture_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_tdc_capture_decoder: scoreboard bench for tdc_capture_decoder            |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_tdc_capture_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] taps;
  logic        start;
  logic        out_ready;
  logic        busy;
  logic        result_valid;
  logic [7:0]  mean, min_cnt, max_cnt;
  logic        sat, empty;

  tdc_capture_decoder #(.N_TAPS(16), .LOG2_SAMPLES(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .taps         (taps),
    .start        (start),
    .out_ready    (out_ready),
    .busy         (busy),
    .result_valid (result_valid),
    .mean         (mean),
    .min_cnt      (min_cnt),
    .max_cnt      (max_cnt),
    .sat          (sat),
    .empty        (empty)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] mean;
    logic [7:0] mn;
    logic [7:0] mx;
    logic       sat;
    logic       empty;
    int         cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   cyc      = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: result fields compared on every valid cycle (checks stability),
  // entry popped on the handshake cycle.
  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_valid: got result_valid=1, expected 0 (cycle %0d)", cyc);
      end else begin
        if (!prev_valid) check("latency", cyc, sb[0].cyc);
        check("mean",    mean,    sb[0].mean);
        check("min_cnt", min_cnt, sb[0].mn);
        check("max_cnt", max_cnt, sb[0].mx);
        check("sat",     sat,     sb[0].sat);
        check("empty",   empty,   sb[0].empty);
        if (out_ready === 1'b1) void'(sb.pop_front());
      end
    end
    prev_valid = (result_valid === 1'b1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] m, input logic [7:0] mn, input logic [7:0] mx,
                      input logic s, input logic e, input int at);
    exp_t x;
    x.mean = m; x.mn = mn; x.mx = mx; x.sat = s; x.empty = e; x.cyc = at;
    sb.push_back(x);
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    check("drain_pending", sb.size(), 0);
    sb.delete();
  endtask

  task automatic measure(input logic [15:0] t, input logic [7:0] m, input logic [7:0] mn,
                         input logic [7:0] mx, input logic s, input logic e);
    taps = t;
    repeat (3) tick();
    push(m, mn, mx, s, e, cyc + 7);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_drain(40);
    tick();
  endtask

  initial begin
    rst       = 1'b1;
    taps      = '0;
    start     = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy",  busy,         0);
    check("rst_valid", result_valid, 0);
    check("rst_mean",  mean,         0);
    check("rst_min",   min_cnt,      0);
    check("rst_max",   max_cnt,      0);
    check("rst_sat",   sat,          0);
    check("rst_empty", empty,        0);
    tick();

    // Constant thermometer code, bubble, saturated and empty lines
    measure(16'h00FF, 8'd8,  8'd8,  8'd8,  1'b0, 1'b0);
    measure(16'h00F7, 8'd7,  8'd7,  8'd7,  1'b0, 1'b0);
    measure(16'hFFFF, 8'd16, 8'd16, 8'd16, 1'b1, 1'b0);
    measure(16'h0000, 8'd0,  8'd0,  8'd0,  1'b0, 1'b1);

    // Alternating 4 / 12 taps every cycle
    taps = 16'h000F;
    repeat (3) tick();
    push(8'd8, 8'd4, 8'd12, 1'b0, 1'b0, cyc + 7);
    start = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      start = 1'b0;
      taps  = (taps == 16'h000F) ? 16'h0FFF : 16'h000F;
    end
    wait_drain(40);
    tick();

    // Consumer stalls in DONE; start pulses there must be ignored
    out_ready = 1'b0;
    taps      = 16'h00FF;
    repeat (3) tick();
    push(8'd8, 8'd8, 8'd8, 1'b0, 1'b0, cyc + 7);
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    for (int i = 0; i < 10; i++) begin
      start = (i == 2 || i == 6);
      @(negedge clk);
      check("hold_valid", result_valid, 1);
      check("hold_busy",  busy,         0);
      tick();
    end
    start     = 1'b0;
    out_ready = 1'b1;
    tick();
    @(negedge clk);
    check("post_hs_valid", result_valid, 0);
    check("post_hs_busy",  busy,         0);
    check("post_hs_queue", sb.size(),    0);
    repeat (3) tick();
    @(negedge clk);
    check("no_queued_start", busy, 0);
    tick();

    // Reset during the second ACCUM cycle discards the measurement
    taps = 16'h00FF;
    repeat (3) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("mid_rst_busy",  busy,         0);
    check("mid_rst_valid", result_valid, 0);
    check("mid_rst_mean",  mean,         0);
    check("mid_rst_min",   min_cnt,      0);
    check("mid_rst_max",   max_cnt,      0);
    check("mid_rst_sat",   sat,          0);
    check("mid_rst_empty", empty,        0);
    tick();
    rst = 1'b0;
    repeat (10) tick();
    measure(16'h0FFF, 8'd12, 8'd12, 8'd12, 1'b0, 1'b0);

    // start held high: a new result every 8 cycles (IDLE cycle + 7 latency)
    taps = 16'h0FFF;
    repeat (3) tick();
    push(8'd12, 8'd12, 8'd12, 1'b0, 1'b0, cyc + 7);
    push(8'd12, 8'd12, 8'd12, 1'b0, 1'b0, cyc + 15);
    push(8'd12, 8'd12, 8'd12, 1'b0, 1'b0, cyc + 23);
    start = 1'b1;
    wait_drain(60);
    start = 1'b0;
    repeat (12) tick();
    @(negedge clk);
    check("final_idle_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
